// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared constants for the sprite compositor: the default geometry and
// widths, and the two background colours shown wherever no sprite is opaque.
// The background colours are 12-bit RGB (4:4:4).
package sprite_pkg;

    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_SPRITE_W    = 75;
    localparam int DEF_SPRITE_H    = 75;
    localparam int DEF_ADDR_W      = 13;
    localparam int DEF_X_W         = 10;
    localparam int DEF_Y_W         = 9;
    localparam int DEF_COLOR_W     = 12;

    localparam logic [11:0] BG_ON_COLOR  = 12'h000;
    localparam logic [11:0] BG_OFF_COLOR = 12'hFFF;

endpackage

// File: rtl/sprite_channel.sv
// sprite_channel
// One sprite slot: it holds the double-buffered position, enable and colour,
// tests whether the current pixel lies inside the sprite box, and forms the
// mask ROM address for that pixel.
//
// Ports:
//   clk, reset          pixel clock, async active-high reset
//   wr                  shadow register write strobe (already decoded for this slot)
//   cfg_x/y/en/color    values written into the shadow registers
//   frame_end           copies the shadow registers into the active registers
//   pix_x, pix_y        current pixel coordinate
//   in_box              pixel lies inside the active sprite box (combinational)
//   addr                mask ROM address, 0 when outside the box (combinational)
//   en, color           active enable and colour
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = DEF_SPRITE_W,
    parameter int SPRITE_H = DEF_SPRITE_H,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOR_W  = DEF_COLOR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [X_W-1:0]     cfg_x,
    input  logic [Y_W-1:0]     cfg_y,
    input  logic               cfg_en,
    input  logic [COLOR_W-1:0] cfg_color,
    input  logic               frame_end,
    input  logic [X_W-1:0]     pix_x,
    input  logic [Y_W-1:0]     pix_y,
    output logic               in_box,
    output logic [ADDR_W-1:0]  addr,
    output logic               en,
    output logic [COLOR_W-1:0] color
);

    logic [X_W-1:0]     sh_x, act_x;
    logic [Y_W-1:0]     sh_y, act_y;
    logic               sh_en, act_en;
    logic [COLOR_W-1:0] sh_color, act_color;

    // On a cycle that has both a write and frame_end, the active copy takes
    // the old shadow value because both updates sample pre-edge state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x      <= '0;
            sh_y      <= '0;
            sh_en     <= 1'b0;
            sh_color  <= '0;
            act_x     <= '0;
            act_y     <= '0;
            act_en    <= 1'b0;
            act_color <= '0;
        end else begin
            if (wr) begin
                sh_x     <= cfg_x;
                sh_y     <= cfg_y;
                sh_en    <= cfg_en;
                sh_color <= cfg_color;
            end
            if (frame_end) begin
                act_x     <= sh_x;
                act_y     <= sh_y;
                act_en    <= sh_en;
                act_color <= sh_color;
            end
        end
    end

    // The box edges are computed one bit wider than the coordinates, so a
    // sprite that runs off the right or bottom edge is clipped, never wrapped.
    logic [X_W:0]   x_ext, x_lo, x_hi;
    logic [Y_W:0]   y_ext, y_lo, y_hi;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    always_comb begin
        x_ext  = {1'b0, pix_x};
        x_lo   = {1'b0, act_x};
        x_hi   = x_lo + (X_W+1)'(SPRITE_W);
        y_ext  = {1'b0, pix_y};
        y_lo   = {1'b0, act_y};
        y_hi   = y_lo + (Y_W+1)'(SPRITE_H);
        in_box = (x_ext >= x_lo) && (x_ext < x_hi) &&
                 (y_ext >= y_lo) && (y_ext < y_hi);
        dx     = pix_x - act_x;
        dy     = pix_y - act_y;
        addr   = '0;
        if (in_box) begin
            addr = ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx);
        end
    end

    assign en    = act_en;
    assign color = act_color;

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor
// Overlays up to NUM_SPRITES 1-bit-mask sprites on a 1-bit background. Each
// pixel takes two cycles: cycle 1 issues the ROM addresses and registers the
// box hits, cycle 2 combines them with the ROM data and registers the colour.
// The lowest-numbered opaque sprite wins.
//
// Optional build macro: SPRITE_COLLISION_EN adds a per-frame collision
// accumulator; without it collision_flags is tied to 0.
//
// Ports:
//   clk, reset          pixel clock, async active-high reset
//   pix_x, pix_y        current pixel coordinate
//   pix_active          visible region
//   frame_end           one-cycle pulse between frames
//   bg_bit              background mask bit for the current pixel
//   cfg_we, cfg_sel     shadow register write strobe and target sprite
//   cfg_x/y/en/color    sprite position, enable and colour
//   spr_addr            mask ROM addresses, sprite i in [i*ADDR_W +: ADDR_W]
//   spr_bit             mask ROM data, one cycle after spr_addr
//   rgb                 composited colour
//   collision_flags     sprites that overlapped another sprite last frame
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int SPRITE_W    = DEF_SPRITE_W,
    parameter int SPRITE_H    = DEF_SPRITE_H,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int COLOR_W     = DEF_COLOR_W,
    localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [X_W-1:0]                pix_x,
    input  logic [Y_W-1:0]                pix_y,
    input  logic                          pix_active,
    input  logic                          frame_end,
    input  logic                          bg_bit,
    input  logic                          cfg_we,
    input  logic [SEL_W-1:0]              cfg_sel,
    input  logic [X_W-1:0]                cfg_x,
    input  logic [Y_W-1:0]                cfg_y,
    input  logic                          cfg_en,
    input  logic [COLOR_W-1:0]            cfg_color,
    output logic [NUM_SPRITES*ADDR_W-1:0] spr_addr,
    input  logic [NUM_SPRITES-1:0]        spr_bit,
    output logic [COLOR_W-1:0]            rgb,
    output logic [NUM_SPRITES-1:0]        collision_flags
);

    logic [NUM_SPRITES-1:0] in_box;
    logic [NUM_SPRITES-1:0] spr_en;
    logic [NUM_SPRITES-1:0] hit;
    logic [COLOR_W-1:0]     spr_color [NUM_SPRITES];

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_chan
        logic wr;

        // The extra compare bit makes a selector beyond the last sprite
        // match nothing, so such writes are dropped.
        assign wr = cfg_we && ({1'b0, cfg_sel} == (SEL_W+1)'(i));

        sprite_channel #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .ADDR_W   (ADDR_W),
            .X_W      (X_W),
            .Y_W      (Y_W),
            .COLOR_W  (COLOR_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .wr        (wr),
            .cfg_x     (cfg_x),
            .cfg_y     (cfg_y),
            .cfg_en    (cfg_en),
            .cfg_color (cfg_color),
            .frame_end (frame_end),
            .pix_x     (pix_x),
            .pix_y     (pix_y),
            .in_box    (in_box[i]),
            .addr      (spr_addr[i*ADDR_W +: ADDR_W]),
            .en        (spr_en[i]),
            .color     (spr_color[i])
        );

        assign hit[i] = in_box[i] && spr_en[i];
    end

    // First stage: hold the pixel's box hits and background alongside the
    // ROM read that is in flight.
    logic [NUM_SPRITES-1:0] hit_q;
    logic                   bg_q;
    logic                   act_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q <= '0;
            bg_q  <= 1'b0;
            act_q <= 1'b0;
        end else begin
            hit_q <= hit;
            bg_q  <= bg_bit;
            act_q <= pix_active;
        end
    end

    logic [NUM_SPRITES-1:0] opaque;
    logic [COLOR_W-1:0]     rgb_next;

    // Scanning from the top index down lets the lowest opaque index win.
    always_comb begin
        opaque   = hit_q & spr_bit;
        rgb_next = '0;
        if (act_q) begin
            rgb_next = bg_q ? COLOR_W'(BG_ON_COLOR) : COLOR_W'(BG_OFF_COLOR);
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                if (opaque[i]) begin
                    rgb_next = spr_color[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= '0;
        end else begin
            rgb <= rgb_next;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] coll_acc;
    logic [NUM_SPRITES-1:0] coll_next;

    // A sprite is flagged when it is opaque on a visible pixel together with
    // at least one other opaque sprite.
    always_comb begin
        coll_next = coll_acc;
        if (act_q && ($countones(opaque) > 1)) begin
            coll_next = coll_acc | opaque;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_acc        <= '0;
            collision_flags <= '0;
        end else if (frame_end) begin
            collision_flags <= coll_next;
            coll_acc        <= '0;
        end else begin
            coll_acc <= coll_next;
        end
    end
`else
    assign collision_flags = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor
// Directed bench for sprite_compositor with default parameters. The mask
// ROMs are modelled as registered all-ones (or all-zeros) memories. Each
// pixel is presented alone, and rgb is read two clock edges later.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_active;
    logic        frame_end;
    logic        bg_bit;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [9:0]  cfg_x;
    logic [8:0]  cfg_y;
    logic        cfg_en;
    logic [11:0] cfg_color;
    logic [51:0] spr_addr;
    logic [3:0]  spr_bit;
    logic [11:0] rgb;
    logic [3:0]  collision_flags;

    logic [3:0]  rom_ones;
    int          vectors = 0;
    int          miscompares = 0;

    sprite_compositor dut (
        .clk             (clk),
        .reset           (reset),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_active      (pix_active),
        .frame_end       (frame_end),
        .bg_bit          (bg_bit),
        .cfg_we          (cfg_we),
        .cfg_sel         (cfg_sel),
        .cfg_x           (cfg_x),
        .cfg_y           (cfg_y),
        .cfg_en          (cfg_en),
        .cfg_color       (cfg_color),
        .spr_addr        (spr_addr),
        .spr_bit         (spr_bit),
        .rgb             (rgb),
        .collision_flags (collision_flags)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears one edge after the address.
    always @(posedge clk) begin
        spr_bit <= rom_ones;
    end

    task automatic write_cfg(input logic [1:0] sel, input logic [9:0] x, input logic [8:0] y,
                             input logic en, input logic [11:0] color, input logic with_fe);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_x = x; cfg_y = y; cfg_en = en; cfg_color = color;
        frame_end = with_fe;
        @(negedge clk);
        cfg_we = 1'b0; frame_end = 1'b0;
    endtask

    task automatic pulse_frame_end();
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [8:0] y, input logic act, input logic bg,
                         output logic [11:0] rgb_o, output logic [51:0] addr_o);
        @(negedge clk);
        pix_x = x; pix_y = y; pix_active = act; bg_bit = bg;
        #1 addr_o = spr_addr;
        @(negedge clk);
        pix_x = '0; pix_y = '0; pix_active = 1'b0; bg_bit = 1'b0;
        @(posedge clk);
        #1 rgb_o = rgb;
    endtask

    task automatic test_reset();
        logic [11:0] c;
        logic [51:0] a;
        vectors++;
        if (rgb !== 12'h000) begin
            $display("[TB] FAIL reset_rgb: got %h expected 000", rgb); miscompares++;
        end
        vectors++;
        if (collision_flags !== 4'b0000) begin
            $display("[TB] FAIL reset_flags: got %b expected 0000", collision_flags); miscompares++;
        end
        pixel(10'd5, 9'd5, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL reset_disabled_rgb: got %h expected FFF", c); miscompares++;
        end
        vectors++;
        if (a[12:0] !== 13'd380) begin
            $display("[TB] FAIL reset_addr: got %0d expected 380", a[12:0]); miscompares++;
        end
        pixel(10'd5, 9'd5, 1'b1, 1'b1, c, a);
        vectors++;
        if (c !== 12'h000) begin
            $display("[TB] FAIL reset_bg_on: got %h expected 000", c); miscompares++;
        end
    endtask

    task automatic test_basic();
        logic [11:0] c;
        logic [51:0] a;
        write_cfg(2'd0, 10'd100, 9'd50, 1'b1, 12'hF00, 1'b0);
        pulse_frame_end();
        pixel(10'd100, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hF00 || a[12:0] !== 13'd0) begin
            $display("[TB] FAIL basic_origin: got rgb %h addr %0d expected F00 0", c, a[12:0]); miscompares++;
        end
        pixel(10'd174, 9'd124, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hF00 || a[12:0] !== 13'd5624) begin
            $display("[TB] FAIL basic_corner: got rgb %h addr %0d expected F00 5624", c, a[12:0]); miscompares++;
        end
        pixel(10'd175, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF || a[12:0] !== 13'd0) begin
            $display("[TB] FAIL basic_right_edge: got rgb %h addr %0d expected FFF 0", c, a[12:0]); miscompares++;
        end
        pixel(10'd99, 9'd60, 1'b1, 1'b1, c, a);
        vectors++;
        if (c !== 12'h000) begin
            $display("[TB] FAIL basic_left_edge: got %h expected 000", c); miscompares++;
        end
        pixel(10'd120, 9'd125, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL basic_bottom_edge: got %h expected FFF", c); miscompares++;
        end
    endtask

    task automatic test_inactive();
        logic [11:0] c;
        logic [51:0] a;
        pixel(10'd120, 9'd60, 1'b0, 1'b0, c, a);
        vectors++;
        if (c !== 12'h000) begin
            $display("[TB] FAIL inactive_blank: got %h expected 000", c); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] c;
        logic [51:0] a;
        pixel(10'd100, 9'd50, 1'b1, 1'b0, c, a);
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (rgb !== 12'h000 || collision_flags !== 4'b0000) begin
            $display("[TB] FAIL midreset_outputs: got rgb %h flags %b expected 000 0000", rgb, collision_flags);
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b0;
        pixel(10'd100, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL midreset_disabled: got %h expected FFF", c); miscompares++;
        end
        pulse_frame_end();
        pixel(10'd100, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL midreset_shadow_cleared: got %h expected FFF", c); miscompares++;
        end
    endtask

    task automatic test_double_buffer();
        logic [11:0] c;
        logic [51:0] a;
        write_cfg(2'd0, 10'd100, 9'd50, 1'b1, 12'hF00, 1'b0);
        pulse_frame_end();
        write_cfg(2'd0, 10'd200, 9'd50, 1'b1, 12'hF00, 1'b0);
        pixel(10'd100, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hF00) begin
            $display("[TB] FAIL dbuf_old_pos: got %h expected F00", c); miscompares++;
        end
        pixel(10'd200, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL dbuf_new_early: got %h expected FFF", c); miscompares++;
        end
        pulse_frame_end();
        pixel(10'd200, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hF00) begin
            $display("[TB] FAIL dbuf_new_pos: got %h expected F00", c); miscompares++;
        end
        write_cfg(2'd0, 10'd300, 9'd50, 1'b1, 12'hF00, 1'b1);
        pixel(10'd300, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL dbuf_coincident_early: got %h expected FFF", c); miscompares++;
        end
        pixel(10'd200, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hF00) begin
            $display("[TB] FAIL dbuf_coincident_hold: got %h expected F00", c); miscompares++;
        end
        pulse_frame_end();
        pixel(10'd300, 9'd50, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hF00) begin
            $display("[TB] FAIL dbuf_coincident_late: got %h expected F00", c); miscompares++;
        end
    endtask

    task automatic test_priority();
        logic [11:0] c;
        logic [51:0] a;
        logic [3:0]  exp_coll;
`ifdef SPRITE_COLLISION_EN
        exp_coll = 4'b0011;
`else
        exp_coll = 4'b0000;
`endif
        write_cfg(2'd0, 10'd10, 9'd10, 1'b1, 12'hF00, 1'b0);
        write_cfg(2'd1, 10'd20, 9'd20, 1'b1, 12'h0F0, 1'b0);
        pulse_frame_end();
        #1;
        vectors++;
        if (collision_flags !== 4'b0000) begin
            $display("[TB] FAIL prio_flags_before: got %b expected 0000", collision_flags); miscompares++;
        end
        pixel(10'd30, 9'd30, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hF00) begin
            $display("[TB] FAIL prio_overlap: got %h expected F00", c); miscompares++;
        end
        pixel(10'd90, 9'd90, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'h0F0) begin
            $display("[TB] FAIL prio_sprite1_only: got %h expected 0F0", c); miscompares++;
        end
        pulse_frame_end();
        #1;
        vectors++;
        if (collision_flags !== exp_coll) begin
            $display("[TB] FAIL coll_set: got %b expected %b", collision_flags, exp_coll); miscompares++;
        end
        write_cfg(2'd1, 10'd300, 9'd300, 1'b1, 12'h0F0, 1'b0);
        pulse_frame_end();
        pixel(10'd30, 9'd30, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hF00) begin
            $display("[TB] FAIL prio_apart: got %h expected F00", c); miscompares++;
        end
        pulse_frame_end();
        #1;
        vectors++;
        if (collision_flags !== 4'b0000) begin
            $display("[TB] FAIL coll_cleared: got %b expected 0000", collision_flags); miscompares++;
        end
    endtask

    task automatic test_clip();
        logic [11:0] c;
        logic [51:0] a;
        write_cfg(2'd0, 10'd10, 9'd10, 1'b0, 12'hF00, 1'b0);
        write_cfg(2'd1, 10'd20, 9'd20, 1'b0, 12'h0F0, 1'b0);
        write_cfg(2'd2, 10'd600, 9'd100, 1'b1, 12'h00F, 1'b0);
        pulse_frame_end();
        pixel(10'd10, 9'd10, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL clip_disabled: got %h expected FFF", c); miscompares++;
        end
        pixel(10'd639, 9'd100, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'h00F || a[38:26] !== 13'd39) begin
            $display("[TB] FAIL clip_last_col: got rgb %h addr %0d expected 00F 39", c, a[38:26]); miscompares++;
        end
        pixel(10'd600, 9'd100, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'h00F || a[38:26] !== 13'd0) begin
            $display("[TB] FAIL clip_first_col: got rgb %h addr %0d expected 00F 0", c, a[38:26]); miscompares++;
        end
        pixel(10'd0, 9'd100, 1'b1, 1'b1, c, a);
        vectors++;
        if (c !== 12'h000 || a[38:26] !== 13'd0) begin
            $display("[TB] FAIL clip_no_wrap0: got rgb %h addr %0d expected 000 0", c, a[38:26]); miscompares++;
        end
        pixel(10'd34, 9'd100, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL clip_no_wrap34: got %h expected FFF", c); miscompares++;
        end
        rom_ones = 4'b1011;
        pixel(10'd610, 9'd110, 1'b1, 1'b0, c, a);
        vectors++;
        if (c !== 12'hFFF) begin
            $display("[TB] FAIL clip_transparent_mask: got %h expected FFF", c); miscompares++;
        end
        rom_ones = 4'b1111;
    endtask

    initial begin
        reset = 1'b1;
        pix_x = '0; pix_y = '0; pix_active = 1'b0; frame_end = 1'b0; bg_bit = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0; cfg_color = '0;
        rom_ones = 4'b1111;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_basic();
        test_inactive();
        test_reset_mid();
        test_double_buffer();
        test_priority();
        test_clip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
